memwb_stage_pipe: RTL and testbench

//  Parametrised MEM->WB pipeline stage register with valid/ready flow control, flush and retire counting.

---
 rtl/cpu_pipe_pkg.sv | 29 ++
 rtl/memwb_skid_slot.sv | 56 +++++
 rtl/memwb_stage_pipe.sv | 128 ++++++++++++
 tb/tb_memwb_stage_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pipe_pkg
//  Description : Shared pipeline types and constants for the MEM->WB stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

    localparam int MEMWB_DATA_W     = 16;
    localparam int MEMWB_REG_ADDR_W = 4;

    localparam logic WBS_MEM  = 1'b1;
    localparam logic WBS_CALC = 1'b0;

    typedef struct packed {
        logic                          wbs;
        logic [MEMWB_DATA_W-1:0]       mem_data;
        logic [MEMWB_DATA_W-1:0]       calc_data;
        logic [MEMWB_REG_ADDR_W-1:0]   rd;
        logic                          ni;
    } memwb_payload_t;

    // Flattened payload width for arbitrary stage parameters; field order matches memwb_payload_t.
    function automatic int memwb_payload_width(input int data_w, input int reg_addr_w);
        return 2 * data_w + reg_addr_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memwb_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_skid_slot
//  Description : One payload register with valid bit; flush > load > clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module memwb_skid_slot
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (clear) begin
            // Payload is left in place on a plain drain; only flush zeroes it.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/memwb_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_stage_pipe
//  Description : MEM->WB stage register with valid/ready, flush and retire
//                counter. Define MEMWB_SKID_EN for a registered in_ready
//                backed by a one-entry skid slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module memwb_stage_pipe
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wbs,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_calc_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_ni,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wbs,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [DATA_W-1:0]     out_calc_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_ni,
    output logic [DATA_W-1:0]     wb_data,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam int c_PAYLOAD_W = memwb_payload_width(DATA_W, REG_ADDR_W);

    logic [c_PAYLOAD_W-1:0] w_in_payload;
    logic [c_PAYLOAD_W-1:0] w_main_d;
    logic [c_PAYLOAD_W-1:0] w_main_q;
    logic                   w_main_valid;
    logic                   w_main_load;
    logic                   w_main_clear;
    logic                   w_out_hs;

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    assign w_in_payload = {in_wbs, in_mem_data, in_calc_data, in_rd, in_ni};
    assign w_out_hs     = w_main_valid && out_ready;

`ifdef MEMWB_SKID_EN
    logic [c_PAYLOAD_W-1:0] w_skid_q;
    logic                   w_skid_valid;
    logic                   w_skid_load;
    logic                   w_skid_clear;
    logic                   w_in_hs;
    logic                   w_main_free;

    // in_ready depends only on the skid flop, breaking the out_ready->in_ready path.
    assign in_ready     = !w_skid_valid;
    assign w_in_hs      = in_valid && !w_skid_valid;
    assign w_main_free  = !w_main_valid || w_out_hs;

    // Skid contents are older than anything on the input, so they drain first.
    assign w_main_load  = w_main_free && (w_skid_valid || w_in_hs);
    assign w_main_d     = w_skid_valid ? w_skid_q : w_in_payload;
    assign w_main_clear = w_out_hs;
    assign w_skid_load  = w_in_hs && !w_main_free;
    assign w_skid_clear = w_main_free && w_skid_valid;

    memwb_skid_slot #(
        .WIDTH (c_PAYLOAD_W)
    ) u_skid_slot (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_in_payload),
        .q     (w_skid_q),
        .valid (w_skid_valid)
    );
`else
    assign in_ready     = !w_main_valid || out_ready;
    assign w_main_load  = in_valid && in_ready;
    assign w_main_d     = w_in_payload;
    assign w_main_clear = w_out_hs;
`endif

    memwb_skid_slot #(
        .WIDTH (c_PAYLOAD_W)
    ) u_main_slot (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (w_main_load),
        .clear (w_main_clear),
        .d     (w_main_d),
        .q     (w_main_q),
        .valid (w_main_valid)
    );

    assign out_valid = w_main_valid;
    assign {out_wbs, out_mem_data, out_calc_data, out_rd, out_ni} = w_main_q;
    assign wb_data   = (out_wbs == WBS_MEM) ? out_mem_data : out_calc_data;

    // Flush does not cancel a handshake that completes in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (w_out_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_memwb_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memwb_stage_pipe
//  Description : Directed, table-driven bench for memwb_stage_pipe (CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memwb_stage_pipe;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_wbs;
    logic [DATA_W-1:0]     in_mem_data;
    logic [DATA_W-1:0]     in_calc_data;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_ni;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_wbs;
    logic [DATA_W-1:0]     out_mem_data;
    logic [DATA_W-1:0]     out_calc_data;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_ni;
    logic [DATA_W-1:0]     wb_data;
    logic [CNT_W-1:0]      retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memwb_stage_pipe #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wbs        (in_wbs),
        .in_mem_data   (in_mem_data),
        .in_calc_data  (in_calc_data),
        .in_rd         (in_rd),
        .in_ni         (in_ni),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wbs       (out_wbs),
        .out_mem_data  (out_mem_data),
        .out_calc_data (out_calc_data),
        .out_rd        (out_rd),
        .out_ni        (out_ni),
        .wb_data       (wb_data),
        .retire_cnt    (retire_cnt)
    );

    typedef struct {
        logic                  vld;
        logic                  wbs;
        logic [DATA_W-1:0]     mem;
        logic [DATA_W-1:0]     calc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ni;
        logic                  exp_valid;
        logic [DATA_W-1:0]     exp_wb;
        logic [REG_ADDR_W-1:0] exp_rd;
        logic                  exp_ni;
        logic [CNT_W-1:0]      exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wbs, input logic [DATA_W-1:0] mem,
                         input logic [DATA_W-1:0] calc, input logic [REG_ADDR_W-1:0] rd,
                         input logic ni);
        in_valid     = v;
        in_wbs       = wbs;
        in_mem_data  = mem;
        in_calc_data = calc;
        in_rd        = rd;
        in_ni        = ni;
    endtask

    initial begin
        // Stream of eight calc payloads, then idle, then writeback-select pair, then idle.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 1'b0, 16'h0000, 16'(i + 1), 4'(i + 1), 1'(i % 2),
                        1'b1, 16'(i + 1), 4'(i + 1), 1'(i % 2), 4'(i)};
        end
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0,
                     1'b0, 16'h0000, 4'h0, 1'b0, 4'd8};
        vecs[9]  = '{1'b1, 1'b1, 16'hBEEF, 16'h1234, 4'h5, 1'b1,
                     1'b1, 16'hBEEF, 4'h5, 1'b1, 4'd8};
        vecs[10] = '{1'b1, 1'b0, 16'hBEEF, 16'h1234, 4'h6, 1'b0,
                     1'b1, 16'h1234, 4'h6, 1'b0, 4'd9};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0,
                     1'b0, 16'h0000, 4'h0, 1'b0, 4'd10};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 4'hF, 1'b1);

        // Reset held two cycles with a valid input present.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_wb_data", 32'(wb_data), 32'd0);
            chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].vld, vecs[i].wbs, vecs[i].mem, vecs[i].calc, vecs[i].rd, vecs[i].ni);
            step();
            chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
            chk("vec_retire_cnt", 32'(retire_cnt), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_valid) begin
                chk("vec_wb_data", 32'(wb_data), 32'(vecs[i].exp_wb));
                chk("vec_out_rd", 32'(out_rd), 32'(vecs[i].exp_rd));
                chk("vec_out_ni", 32'(out_ni), 32'(vecs[i].exp_ni));
            end
        end

        // Stall with 0xA5A5 held, second payload 0x5A5A offered behind it.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 16'hA5A5, 4'h3, 1'b1);
        step();
        chk("stall_load_valid", 32'(out_valid), 32'd1);
        chk("stall_load_wb", 32'(wb_data), 32'hA5A5);
        drive(1'b1, 1'b0, 16'h0000, 16'h5A5A, 4'h4, 1'b0);
        #1;
`ifdef MEMWB_SKID_EN
        chk("stall_in_ready_skid_free", 32'(in_ready), 32'd1);
`else
        chk("stall_in_ready_full", 32'(in_ready), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_wb", 32'(wb_data), 32'hA5A5);
            chk("stall_rd", 32'(out_rd), 32'd3);
            chk("stall_ni", 32'(out_ni), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_cnt", 32'(retire_cnt), 32'd10);
        end
        // Release: 0xA5A5 retires this edge, 0x5A5A follows exactly once.
        out_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_wb", 32'(wb_data), 32'h5A5A);
        chk("release_rd", 32'(out_rd), 32'd4);
        chk("release_cnt", 32'(retire_cnt), 32'd11);
        step();
        chk("release_drain_valid", 32'(out_valid), 32'd0);
        chk("release_drain_cnt", 32'(retire_cnt), 32'd12);

        // Flush against a stalled entry with a new input in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h7777, 16'h0001, 4'h9, 1'b1);
        step();
        chk("flush_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        drive(1'b1, 1'b0, 16'h1111, 16'h1111, 4'hA, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_wb", 32'(wb_data), 32'd0);
        chk("flush_rd", 32'(out_rd), 32'd0);
        chk("flush_calc", 32'(out_calc_data), 32'd0);
        chk("flush_mem", 32'(out_mem_data), 32'd0);
        chk("flush_cnt", 32'(retire_cnt), 32'd12);
        out_ready = 1'b1;
        step();
        chk("flush_input_lost", 32'(out_valid), 32'd0);

        // Flush coinciding with an output handshake still counts that retire.
        drive(1'b1, 1'b0, 16'h0, 16'h2222, 4'h2, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_hs_valid", 32'(out_valid), 32'd0);
        chk("flush_hs_cnt", 32'(retire_cnt), 32'd13);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 16'h0, 16'h3333, 4'h7, 1'b1);
        step();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        step();
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnt", 32'(retire_cnt), 32'd0);
        chk("midrst_wb", 32'(wb_data), 32'd0);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        // Seventeen back-to-back handshakes wrap the 4-bit counter to 1.
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 16'h0, 16'(16'h0100 + i), 4'(i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        chk("wrap_last_wb", 32'(wb_data), 32'h0110);
        chk("wrap_pre_cnt", 32'(retire_cnt), 32'd0);
        step();
        chk("wrap_cnt", 32'(retire_cnt), 32'd1);
        chk("wrap_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
